// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU bus arbiter: FSM state codes, grant encodings
// and the default watchdog limit.
package alu_arb_pkg;

    localparam int DEFAULT_TIMEOUT = 255;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_OWN0  = 3'd1;
    localparam logic [2:0] ST_OWN1  = 3'd2;
    localparam logic [2:0] ST_LOCK0 = 3'd3;
    localparam logic [2:0] ST_LOCK1 = 3'd4;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/alu_arb_watchdog.sv
// Stall counter for the arbiter: counts unterminated strobe cycles and pulses
// fire on the cycle the count reaches TIMEOUT.
module alu_arb_watchdog
    import alu_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable,
    input  logic stb,
    input  logic term,
    output logic fire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;
    logic             stall;

    // A slave termination in the same cycle wins over the watchdog.
    assign stall = enable & stb & ~term;
    assign fire  = stall && (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (!stall || fire) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_bus_arbiter.sv
// Two-master round-robin arbiter with bus lock in front of the ALU slave port.
// Request path is registered through the FSM; response path is combinational.
module alu_bus_arbiter
    import alu_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic              m0_lock_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    input  logic [SEL_W-1:0]  m0_sel_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic              m0_rty_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic              m1_lock_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    input  logic [SEL_W-1:0]  m1_sel_i,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              m1_rty_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic              s_lock_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_dat_o,
    output logic [SEL_W-1:0]  s_sel_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic              s_rty_i,
    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    logic [2:0] state, state_nxt;
    logic       last, last_nxt;
    logic       own0, own1, owning, sel1;
    logic       term, fire;

    assign own0   = (state == ST_OWN0);
    assign own1   = (state == ST_OWN1);
    assign owning = own0 | own1;
    assign sel1   = own1 | (state == ST_LOCK1);
    assign term   = s_ack_i | s_err_i | s_rty_i;

    alu_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .enable (owning),
        .stb    (sel1 ? m1_stb_i : m0_stb_i),
        .term   (term),
        .fire   (fire)
    );

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            ST_IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last)) begin
                    state_nxt = ST_OWN0;
                    last_nxt  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_nxt = ST_OWN1;
                    last_nxt  = 1'b1;
                end
            end
            ST_OWN0:  if (!m0_cyc_i) state_nxt = m0_lock_i ? ST_LOCK0 : ST_IDLE;
            ST_OWN1:  if (!m1_cyc_i) state_nxt = m1_lock_i ? ST_LOCK1 : ST_IDLE;
            ST_LOCK0: begin
                if (m0_cyc_i)       state_nxt = ST_OWN0;
                else if (!m0_lock_i) state_nxt = ST_IDLE;
            end
            ST_LOCK1: begin
                if (m1_cyc_i)       state_nxt = ST_OWN1;
                else if (!m1_lock_i) state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // last resets to master 1 so master 0 wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        s_cyc_o  = owning & (sel1 ? m1_cyc_i  : m0_cyc_i);
        s_stb_o  = owning & (sel1 ? m1_stb_i  : m0_stb_i) & ~fire;
        s_we_o   = owning & (sel1 ? m1_we_i   : m0_we_i);
        s_lock_o = owning & (sel1 ? m1_lock_i : m0_lock_i);
        s_addr_o = owning ? (sel1 ? m1_addr_i : m0_addr_i) : '0;
        s_dat_o  = owning ? (sel1 ? m1_dat_i  : m0_dat_i)  : '0;
        s_sel_o  = owning ? (sel1 ? m1_sel_i  : m0_sel_i)  : '0;

        m0_dat_o = own0 ? s_dat_i : '0;
        m0_ack_o = own0 & s_ack_i;
        m0_err_o = own0 & (s_err_i | fire);
        m0_rty_o = own0 & s_rty_i;
        m1_dat_o = own1 ? s_dat_i : '0;
        m1_ack_o = own1 & s_ack_i;
        m1_err_o = own1 & (s_err_i | fire);
        m1_rty_o = own1 & s_rty_i;

        timeout_o = fire;
    end

    // A locked master still holds the grant while its cycle is paused.
    always_comb begin
        case (state)
            ST_OWN0, ST_LOCK0: grant_o = GNT_M0;
            ST_OWN1, ST_LOCK1: grant_o = GNT_M1;
            default:           grant_o = GNT_NONE;
        endcase
    end

endmodule

// File: tb/tb_alu_bus_arbiter.sv
// Bench for alu_bus_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_alu_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          m_cyc  [2];
    logic          m_stb  [2];
    logic          m_we   [2];
    logic          m_lock [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_dat  [2];
    logic [SW-1:0] m_sel  [2];

    logic [DW-1:0] m0_rdat, m1_rdat;
    logic          m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic          s_cyc, s_stb, s_we, s_lock;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdat;
    logic [SW-1:0] s_sel;
    logic [DW-1:0] s_rdat;
    logic          s_ack, s_err, s_rty;
    logic [1:0]    grant;
    logic          tmo;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: owner (-1 = nobody), paused-by-lock flag, last winner, stall count.
    int own = -1;
    bit lk  = 1'b0;
    bit lst = 1'b1;
    int cnt = 0;

    always #5 clk = ~clk;

    alu_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_lock_i(m_lock[0]),
        .m0_addr_i(m_addr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]),
        .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_lock_i(m_lock[1]),
        .m1_addr_i(m_addr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]),
        .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_lock_o(s_lock),
        .s_addr_o(s_addr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
        .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant), .timeout_o(tmo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_fire();
        if (own < 0 || lk) return 1'b0;
        return m_stb[own] && !(s_ack || s_err || s_rty) && (cnt == TO - 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        bit f;
        if (rst) begin
            own = -1; lk = 1'b0; lst = 1'b1; cnt = 0;
        end else begin
            f = model_fire();
            if (own >= 0 && !lk && m_stb[own] && !(s_ack || s_err || s_rty) && !f)
                cnt = (cnt < 7) ? cnt + 1 : 7;
            else
                cnt = 0;
            if (own < 0) begin
                if (m_cyc[0] && m_cyc[1]) own = lst ? 0 : 1;
                else if (m_cyc[0])        own = 0;
                else if (m_cyc[1])        own = 1;
                if (own >= 0) lst = (own == 1);
            end else if (!lk) begin
                if (!m_cyc[own]) begin
                    if (m_lock[own]) lk = 1'b1;
                    else             own = -1;
                end
            end else begin
                if (m_cyc[own]) lk = 1'b0;
                else if (!m_lock[own]) begin
                    lk = 1'b0; own = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic          e_cyc, e_stb, e_we, e_lock, f;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdat;
        logic [SW-1:0] e_sel;
        logic [DW-1:0] e_rd [2];
        logic          e_ack [2], e_err [2], e_rty [2];
        logic [1:0]    e_gnt;
        e_cyc = 0; e_stb = 0; e_we = 0; e_lock = 0; f = 0;
        e_addr = '0; e_wdat = '0; e_sel = '0; e_gnt = 2'b00;
        for (int i = 0; i < 2; i++) begin
            e_rd[i] = '0; e_ack[i] = 0; e_err[i] = 0; e_rty[i] = 0;
        end
        if (!rst && own >= 0) begin
            e_gnt = (own == 0) ? 2'b01 : 2'b10;
            if (!lk) begin
                f      = model_fire();
                e_cyc  = m_cyc[own];
                e_stb  = m_stb[own] && !f;
                e_we   = m_we[own];
                e_lock = m_lock[own];
                e_addr = m_addr[own];
                e_wdat = m_dat[own];
                e_sel  = m_sel[own];
                e_rd[own]  = s_rdat;
                e_ack[own] = s_ack;
                e_err[own] = s_err || f;
                e_rty[own] = s_rty;
            end
        end
        chk("s_cyc", s_cyc, e_cyc);
        chk("s_stb", s_stb, e_stb);
        chk("s_we", s_we, e_we);
        chk("s_lock", s_lock, e_lock);
        chk("s_addr", s_addr, e_addr);
        chk("s_dat", s_wdat, e_wdat);
        chk("s_sel", s_sel, e_sel);
        chk("m0_dat", m0_rdat, e_rd[0]);
        chk("m0_ack", m0_ack, e_ack[0]);
        chk("m0_err", m0_err, e_err[0]);
        chk("m0_rty", m0_rty, e_rty[0]);
        chk("m1_dat", m1_rdat, e_rd[1]);
        chk("m1_ack", m1_ack, e_ack[1]);
        chk("m1_err", m1_err, e_err[1]);
        chk("m1_rty", m1_rty, e_rty[1]);
        chk("grant", grant, e_gnt);
        chk("timeout", tmo, f);
    end

    task automatic clear_in();
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 0; m_stb[i] = 0; m_we[i] = 0; m_lock[i] = 0;
            m_addr[i] = '0; m_dat[i] = '0; m_sel[i] = '0;
        end
        s_rdat = '0; s_ack = 0; s_err = 0; s_rty = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic stall_run(input bit ack_on_last);
        do_reset();
        m_cyc[0] = 1; m_stb[0] = 1; m_addr[0] = 32'h40;
        tick();
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk("wd_early_err", m0_err, 1'b0);
            chk("wd_early_tmo", tmo, 1'b0);
            tick();
        end
        s_ack = ack_on_last;
        #1;
        chk("wd_last_err", m0_err, !ack_on_last);
        chk("wd_last_tmo", tmo, !ack_on_last);
        chk("wd_last_stb", s_stb, ack_on_last);
        chk("wd_last_ack", m0_ack, ack_on_last);
        chk("wd_last_cyc", s_cyc, 1'b1);
        clear_in();
        tick();
    endtask

    initial begin
        logic [1:0] exp_order [3];
        exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01;

        do_reset();
        chk("rst_grant", grant, 2'b00);
        chk("rst_cyc", s_cyc, 1'b0);
        chk("rst_tmo", tmo, 1'b0);
        chk("rst_ack", m0_ack, 1'b0);

        // m0 single read
        m_cyc[0] = 1; m_stb[0] = 1; m_addr[0] = 32'h10; m_sel[0] = 8'h0F;
        #1 chk("rd_latency_cyc", s_cyc, 1'b0);
        tick();
        chk("rd_cyc", s_cyc, 1'b1);
        chk("rd_addr", s_addr, 32'h10);
        s_ack = 1; s_rdat = 32'hDEADBEEF;
        #1;
        chk("rd_data", m0_rdat, 32'hDEADBEEF);
        chk("rd_ack", m0_ack, 1'b1);
        chk("rd_m1_ack", m1_ack, 1'b0);
        tick();
        clear_in();

        // simultaneous requests, three rounds
        do_reset();
        for (int r = 0; r < 3; r++) begin
            m_cyc[0] = 1; m_stb[0] = 1; m_cyc[1] = 1; m_stb[1] = 1;
            tick();
            chk("rr_grant", grant, exp_order[r]);
            m_cyc[0] = 0; m_stb[0] = 0; m_cyc[1] = 0; m_stb[1] = 0;
            tick();
            chk("rr_idle_grant", grant, 2'b00);
            chk("rr_idle_cyc", s_cyc, 1'b0);
        end

        // m1 lock holds off m0
        do_reset();
        m_cyc[1] = 1; m_stb[1] = 1; m_lock[1] = 1;
        tick();
        chk("lk_own1", grant, 2'b10);
        m_cyc[1] = 0; m_stb[1] = 0; m_cyc[0] = 1; m_stb[0] = 1;
        tick();
        chk("lk_hold_grant", grant, 2'b10);
        chk("lk_hold_cyc", s_cyc, 1'b0);
        tick();
        chk("lk_hold2_grant", grant, 2'b10);
        m_cyc[1] = 1; m_stb[1] = 1;
        tick();
        chk("lk_regrant", grant, 2'b10);
        chk("lk_regrant_cyc", s_cyc, 1'b1);
        m_cyc[1] = 0; m_stb[1] = 0; m_lock[1] = 0;
        tick();
        chk("lk_release_idle", grant, 2'b00);
        tick();
        chk("lk_m0_grant", grant, 2'b01);
        clear_in();

        stall_run(1'b0);
        stall_run(1'b1);

        // async reset in the middle of an m1 write
        do_reset();
        m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 1;
        m_addr[1] = 32'hA0; m_dat[1] = 32'h1234_5678; m_sel[1] = 8'h0F;
        tick();
        chk("ar_cyc", s_cyc, 1'b1);
        chk("ar_we", s_we, 1'b1);
        s_ack = 1;
        #1 chk("ar_ack", m1_ack, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("ar_rst_cyc", s_cyc, 1'b0);
        chk("ar_rst_stb", s_stb, 1'b0);
        chk("ar_rst_we", s_we, 1'b0);
        chk("ar_rst_addr", s_addr, 32'h0);
        chk("ar_rst_dat", s_wdat, 32'h0);
        chk("ar_rst_ack", m1_ack, 1'b0);
        chk("ar_rst_grant", grant, 2'b00);
        #1 rst = 1'b0;
        clear_in();
        tick();

        // randomized traffic, checked by the per-cycle compare process
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(3) == 0) m_cyc[i] = ~m_cyc[i];
                m_stb[i]  = m_cyc[i] && ($urandom_range(2) != 0);
                m_we[i]   = $urandom_range(1) == 1;
                m_lock[i] = $urandom_range(2) == 0;
                m_addr[i] = $urandom;
                m_dat[i]  = $urandom;
                m_sel[i]  = 8'($urandom_range(255));
            end
            s_rdat = $urandom;
            s_ack  = $urandom_range(4) == 0;
            s_err  = $urandom_range(19) == 0;
            s_rty  = $urandom_range(19) == 0;
        end
        tick();
        clear_in();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
